// File: rtl/bp_fe_queue_tx_if.sv
// FE queue packet channel between the FE transmitter and the BE issue queue.
// Valid/ready-and handshake; master drives the packet and valid.
interface bp_fe_queue_tx_if #(
  parameter int vaddr_width_p               = 39,
  parameter int branch_metadata_fwd_width_p = 36
);
  localparam int fe_queue_width_lp = 2 + vaddr_width_p + 32 + branch_metadata_fwd_width_p;

  logic [fe_queue_width_lp-1:0] fe_queue;
  logic                         fe_queue_v;
  logic                         fe_queue_ready;

  modport master (output fe_queue, output fe_queue_v, input fe_queue_ready);
  modport slave  (input fe_queue, input fe_queue_v, output fe_queue_ready);
endinterface

// File: rtl/bp_fe_queue_tx.sv
// FE-side fetch-queue transmitter: packs fetch results into FE queue packets,
// buffers two of them, and stalls after an exception until the BE flushes.
module bp_fe_queue_tx #(
  parameter int vaddr_width_p               = 39,
  parameter int branch_metadata_fwd_width_p = 36,
  localparam int fe_queue_width_lp = 2 + vaddr_width_p + 32 + branch_metadata_fwd_width_p
) (
  input  logic                                   clk_i,
  input  logic                                   reset_n_i,
  input  logic                                   fetch_v_i,
  output logic                                   fetch_ready_o,
  input  logic [vaddr_width_p-1:0]               fetch_pc_i,
  input  logic [31:0]                            fetch_instr_i,
  input  logic [branch_metadata_fwd_width_p-1:0] fetch_meta_i,
  input  logic                                   fetch_exc_v_i,
  input  logic [1:0]                             fetch_exc_code_i,
  input  logic                                   flush_i,
  bp_fe_queue_tx_if.master                       fe_queue_if,
  output logic                                   exc_pending_o
);

  typedef enum logic {e_run = 1'b0, e_wait = 1'b1} state_e;

  state_e                       state_r, state_n;
  logic [fe_queue_width_lp-1:0] entry_r [2];
  logic                         head_r, tail_r;
  logic [1:0]                   count_r;
  logic [fe_queue_width_lp-1:0] pkt_s;
  logic                         enq_s, deq_s;

  // Handshake qualifiers; flush masks both sides in the same cycle
  always_comb begin
    fetch_ready_o          = (state_r == e_run) && (count_r != 2'd2) && !flush_i;
    fe_queue_if.fe_queue_v = (count_r != 2'd0) && !flush_i;
    fe_queue_if.fe_queue   = (count_r != 2'd0) ? entry_r[head_r] : '0;
    exc_pending_o          = (state_r == e_wait);
    enq_s                  = fetch_v_i && fetch_ready_o;
    deq_s                  = fe_queue_if.fe_queue_v && fe_queue_if.fe_queue_ready;
  end

  // Packet formatting: exceptions carry the code in the instr field, zero metadata
  always_comb begin
    pkt_s = '0;
    if (fetch_exc_v_i) begin
      pkt_s = {{branch_metadata_fwd_width_p{1'b0}}, 30'd0, fetch_exc_code_i, fetch_pc_i, 2'd1};
    end else begin
      pkt_s = {fetch_meta_i, fetch_instr_i, fetch_pc_i, 2'd0};
    end
  end

  // Next-state logic: WAIT is left only by a flush
  always_comb begin
    state_n = state_r;
    if (flush_i) begin
      state_n = e_run;
    end else begin
      case (state_r)
        e_run:   state_n = (enq_s && fetch_exc_v_i) ? e_wait : e_run;
        e_wait:  state_n = e_wait;
        default: state_n = e_run;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= e_run;
    end else begin
      state_r <= state_n;
    end
  end

  // Two-entry FIFO storage, pointers and occupancy
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      entry_r[0] <= '0;
      entry_r[1] <= '0;
      head_r     <= 1'b0;
      tail_r     <= 1'b0;
      count_r    <= 2'd0;
    end else if (flush_i) begin
      head_r  <= 1'b0;
      tail_r  <= 1'b0;
      count_r <= 2'd0;
    end else begin
      if (enq_s) begin
        entry_r[tail_r] <= pkt_s;
        tail_r          <= ~tail_r;
      end
      if (deq_s) begin
        head_r <= ~head_r;
      end
      case ({enq_s, deq_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: doc/bp_fe_queue_tx.md
# bp_fe_queue_tx

FE-side transmitter for the FE→BE fetch queue. It takes fetch results (PC, instruction, branch metadata, or a fetch exception) from the FE fetch pipeline and packs them into FE queue packets. It buffers up to two packets and drives them to the BE issue queue over a valid/ready-and handshake. It also enforces the FE rule that after an exception packet, nothing more is sent until the BE redirects (flush).

## Interface
Parameters:
- vaddr_width_p, 39, virtual PC width
- branch_metadata_fwd_width_p, 36, opaque branch metadata width
- localparam fe_queue_width_lp, 2+vaddr_width_p+32+branch_metadata_fwd_width_p, packet width

Ports:
- clk_i  input  1  sole clock; all state on posedge
- reset_n_i  input  1  asynchronous active-low reset
- fetch_v_i  input  1  fetch result valid
- fetch_ready_o  output  1  transmitter accepts fetch result this cycle
- fetch_pc_i  input  vaddr_width_p  fetch PC
- fetch_instr_i  input  32  fetched instruction
- fetch_meta_i  input  branch_metadata_fwd_width_p  branch metadata
- fetch_exc_v_i  input  1  result is an exception, not an instruction
- fetch_exc_code_i  input  2  0 itlb miss, 1 instr page fault, 2 instr access fault, 3 misaligned
- flush_i  input  1  BE redirect / FE flush
- fe_queue_o  output  fe_queue_width_lp  packet at head
- fe_queue_v_o  output  1  head packet valid
- fe_queue_ready_i  input  1  BE issue queue accepts (ready-and)
- exc_pending_o  output  1  in WAIT state

## Operation
- Packet layout (LSB first):
  - [1:0] msg_type: 0 fetch, 1 exception
  - [2 +: vaddr_width_p] pc
  - next 32 bits: instr. For exceptions this field is {30'b0, exc_code}.
  - top branch_metadata_fwd_width_p bits: metadata. Metadata is zero for exceptions.
- Storage: 2-entry FIFO with head/tail pointers (1 bit each) and a 2-bit count (0..2).
- enq = fetch_v_i & fetch_ready_o. deq = fe_queue_v_o & fe_queue_ready_i.
- fetch_ready_o = (state==RUN) & (count!=2) & ~flush_i.
- fe_queue_v_o = (count!=0) & ~flush_i. fe_queue_o = entry[head]; it is all-zero when count==0.
- FSM:
  - RUN: normal. An enq with fetch_exc_v_i=1 writes an exception packet and moves to WAIT.
  - WAIT: fetch_ready_o=0. Entries already buffered, including the exception packet, keep draining in order. Leave WAIT only on flush_i, returning to RUN.
  - flush_i in any state: count←0, both pointers←0, state←RUN. The same-cycle enq is blocked (ready low) and the same-cycle deq is blocked (valid low).
- Count update: +1 on enq only, −1 on deq only, unchanged on both or neither. Pointers wrap modulo 2.
- enq and deq together at count 1 are legal; count stays 1 and the new entry lands in the other slot.
- enq at count 0 with same-cycle deq is impossible, because valid is low.

## Timing
- Reset (async assert, sync deassert by env): count=0, pointers=0, state=RUN, all entries zero. Outputs: fe_queue_v_o=0, fe_queue_o=0, fetch_ready_o=1, exc_pending_o=0.
- Latency: a result accepted in cycle N appears on fe_queue_o with fe_queue_v_o=1 in cycle N+1 if the FIFO was empty.
- fe_queue_o and fe_queue_v_o hold stable while valid and not ready.
- Throughput: 1 packet/cycle sustained when fe_queue_ready_i stays high.
- fetch_ready_o depends on registered state plus flush_i. It never depends on fe_queue_ready_i, so there is no combinational path ready_i→ready_o.
- After flush_i in cycle N: fetch_ready_o=1 in N+1 and fe_queue_v_o=0 in N+1.
- Reset asserted mid-transfer discards all entries immediately, with outputs going low asynchronously.

## Test plan
- Reset, then fetch pc=0x1000 instr=0x00000013 meta=0x5, with ready_i=1: the next cycle shows v_o=1, msg_type=0, pc=0x1000, instr=0x13, meta=0x5. The packet dequeues that cycle and count returns to 0.
- Hold ready_i=0 and offer 3 fetches (pc 0x0, 0x4, 0x8): fetch_ready_o drops after 2 accepts. Raising ready_i drains 0x0 then 0x4 in order. The third fetch is accepted once count<2.
- Exception: fetch pc=0x2000 with exc_v=1, code=1 while 0x1FFC is buffered. Required: 0x1FFC is sent, then an exception packet with instr=0x1, meta=0. fetch_ready_o=0 and exc_pending_o=1 until flush.
- Flush with count=2 and fetch_v_i=1: that cycle v_o=0 and fetch_ready_o=0. The next cycle count=0, state RUN, ready=1, and neither buffered packet is ever sent.
- Steady stream of 8 fetches with ready_i=1 and enq/deq overlapping at count 1: all 8 arrive in order with no gaps after the first, and count never exceeds 1.
- Async reset asserted mid-cycle with count=2 and ready_i=0: v_o goes to 0 immediately. After deassert, outputs match the reset values.
